// File: rtl/pe_inject_scheduler.sv
// Round-robin, packet-locked arbiter for one PE's NoC injection port.
// A credit counter mirrors the router's local-port buffer space.
module pe_inject_scheduler #(
    parameter int N       = 4,
    parameter int FLIT_W  = 20,
    parameter int CREDITS = 7,
    parameter int CNT_W   = 3
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [N-1:0]        req,
    input  logic [N*FLIT_W-1:0] flit_in,
    input  logic [N-1:0]        last,
    output logic [N-1:0]        gnt,
    input  logic                ci,
    output logic [FLIT_W-1:0]   dataout,
    output logic                out_valid,
    output logic [CNT_W-1:0]    credit_cnt,
    output logic                busy,
    output logic                err_ovf
);

    localparam int PW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CNT_W-1:0] CMAX = CNT_W'(CREDITS);

    typedef enum logic {IDLE, LOCKED} state_t;

    state_t          state, state_nx;
    logic [PW-1:0]   owner, owner_nx;
    logic [PW-1:0]   rr_ptr, rr_ptr_nx;
    logic [PW-1:0]   pick;
    logic            found;
    logic            has_credit;
    logic            accept;
    logic            inc;
    logic [CNT_W-1:0] cnt_nx;

    // First requester at or after rr_ptr, wrapping modulo N.
    always_comb begin
        int j;
        j     = 0;
        pick  = '0;
        found = 1'b0;
        for (int k = 0; k < N; k++) begin
            j = int'(rr_ptr) + k;
            if (j >= N) j = j - N;
            if (!found && req[j]) begin
                found = 1'b1;
                pick  = PW'(j);
            end
        end
    end

    assign has_credit = (credit_cnt != '0);
    assign busy       = (state == LOCKED);

    always_comb begin
        gnt = '0;
        if (state == LOCKED) gnt[owner] = has_credit;
    end

    assign accept = (state == LOCKED) && req[owner] && has_credit;

    // At the ceiling a credit is only absorbed if a flit leaves the same cycle.
    assign inc    = ci && ((credit_cnt != CMAX) || accept);
    assign cnt_nx = credit_cnt + CNT_W'(inc) - CNT_W'(accept);

    always_comb begin
        state_nx  = state;
        owner_nx  = owner;
        rr_ptr_nx = rr_ptr;
        unique case (state)
            IDLE: begin
                if (found) begin
                    owner_nx = pick;
                    state_nx = LOCKED;
                end
            end
            LOCKED: begin
                if (accept && last[owner]) begin
                    state_nx  = IDLE;
                    rr_ptr_nx = (int'(owner) == N - 1) ? '0 : owner + 1'b1;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            owner      <= '0;
            rr_ptr     <= '0;
            credit_cnt <= CMAX;
            dataout    <= '0;
            out_valid  <= 1'b0;
            err_ovf    <= 1'b0;
        end else begin
            state      <= state_nx;
            owner      <= owner_nx;
            rr_ptr     <= rr_ptr_nx;
            credit_cnt <= cnt_nx;
            out_valid  <= accept;
            if (accept) dataout <= flit_in[int'(owner)*FLIT_W +: FLIT_W];
            if (ci && (credit_cnt == CMAX) && !accept) err_ovf <= 1'b1;
        end
    end

endmodule
